// File: rtl/pop_timers_pkg.sv
// Shared phase type, register widths and timing constants for the POP sequence generator.
// Autorepeat constants exist only when POP_TIMERS_AUTOREPEAT_EN is defined.
package pop_timers_pkg;

   typedef enum logic [2:0] {
      PH_PUMP,
      PH_WAIT1,
      PH_MW1,
      PH_FREE,
      PH_MW2,
      PH_WAIT2,
      PH_PROBE
   } phase_e;

   localparam int PI2_W  = 8;
   localparam int FREE_W = 12;
   localparam int CNT_W  = 16;

   localparam int PUMP_CYC   = 1000;
   localparam int WAIT1_CYC  = 50;
   localparam int WAIT2_CYC  = 50;
   localparam int PROBE_CYC  = 500;
   localparam int SAMPLE_DLY = 50;

   localparam int PI2_DEF  = 25;
   localparam int PI2_STEP = 1;
   localparam int PI2_MIN  = 1;
   localparam int PI2_MAX  = 255;

   localparam int FREE_DEF  = 1250;
   localparam int FREE_STEP = 25;
   localparam int FREE_MIN  = 25;
   localparam int FREE_MAX  = 4000;

`ifdef POP_TIMERS_AUTOREPEAT_EN
   // 0.5 s hold before the first repeat, then one step every 100 ms at 2.5 MHz
   localparam int AR_W      = 21;
   localparam int AR_DELAY  = 1250000;
   localparam int AR_PERIOD = 250000;
`endif

   function automatic phase_e next_phase(input phase_e p);
      phase_e n;
      case (p)
         PH_PUMP:  n = PH_WAIT1;
         PH_WAIT1: n = PH_MW1;
         PH_MW1:   n = PH_FREE;
         PH_FREE:  n = PH_MW2;
         PH_MW2:   n = PH_WAIT2;
         PH_WAIT2: n = PH_PROBE;
         default:  n = PH_PUMP;
      endcase
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] phase_len(input phase_e p,
                                                   input logic [PI2_W-1:0] pi2,
                                                   input logic [FREE_W-1:0] fp);
      logic [CNT_W-1:0] n;
      case (p)
         PH_PUMP:        n = CNT_W'(PUMP_CYC);
         PH_WAIT1:       n = CNT_W'(WAIT1_CYC);
         PH_MW1, PH_MW2: n = CNT_W'(pi2);
         PH_FREE:        n = CNT_W'(fp);
         PH_WAIT2:       n = CNT_W'(WAIT2_CYC);
         default:        n = CNT_W'(PROBE_CYC);
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pop_timers_if.sv
// Front-panel controls and timing outputs of the POP sequence generator, plus the phase for debug.
interface pop_timers_if;
   import pop_timers_pkg::*;

   // No valid/ready handshake: controls are levels sampled on falling clk_2M5 edges (steps act
   // on 0->1 only); outputs and phase are registered levels that change only on falling edges.
   logic   load_defaults;
   logic   pieovertwo_plus;
   logic   pieovertwo_minus;
   logic   freeprecess_plus;
   logic   freeprecess_minus;
   logic   pump;
   logic   probe;
   logic   MW;
   logic   sample;
   phase_e phase;

   modport master (
      output load_defaults, pieovertwo_plus, pieovertwo_minus, freeprecess_plus, freeprecess_minus,
      input  pump, probe, MW, sample, phase
   );

   modport slave (
      input  load_defaults, pieovertwo_plus, pieovertwo_minus, freeprecess_plus, freeprecess_minus,
      output pump, probe, MW, sample, phase
   );

endinterface

// File: rtl/pop_step_adjust.sv
// Edge-triggered saturating up/down adjust register for one POP timing value.
// Define POP_TIMERS_AUTOREPEAT_EN to add hold-to-repeat on the step inputs.
module pop_step_adjust
   import pop_timers_pkg::*;
#(
   parameter int W    = 8,
   parameter int DEF  = 25,
   parameter int STEP = 1,
   parameter int MIN  = 1,
   parameter int MAX  = 255
) (
   input  logic         clk_2M5,
   input  logic         rst_n,
   input  logic         load_defaults,
   input  logic         plus,
   input  logic         minus,
   output logic [W-1:0] value
);

   logic         plus_q, plus_d, plus_prev_q, plus_prev_d;
   logic         minus_q, minus_d, minus_prev_q, minus_prev_d;
   logic [W-1:0] value_q, value_d;
   logic         plus_rep, minus_rep;
   logic         plus_step, minus_step;

`ifdef POP_TIMERS_AUTOREPEAT_EN
   logic [AR_W-1:0] plus_hold_q, plus_hold_d, minus_hold_q, minus_hold_d;

   always_comb begin
      plus_rep    = 1'b0;
      minus_rep   = 1'b0;
      plus_hold_d  = '0;
      minus_hold_d = '0;
      // After the first repeat the counter rewinds so later repeats come every AR_PERIOD
      if (plus_q && plus_prev_q) begin
         if (plus_hold_q == AR_W'(AR_DELAY - 1)) begin
            plus_rep    = 1'b1;
            plus_hold_d = AR_W'(AR_DELAY - AR_PERIOD);
         end else begin
            plus_hold_d = plus_hold_q + 1'b1;
         end
      end
      if (minus_q && minus_prev_q) begin
         if (minus_hold_q == AR_W'(AR_DELAY - 1)) begin
            minus_rep    = 1'b1;
            minus_hold_d = AR_W'(AR_DELAY - AR_PERIOD);
         end else begin
            minus_hold_d = minus_hold_q + 1'b1;
         end
      end
   end

   always_ff @(negedge clk_2M5 or negedge rst_n) begin
      if (!rst_n) begin
         plus_hold_q  <= '0;
         minus_hold_q <= '0;
      end else begin
         plus_hold_q  <= plus_hold_d;
         minus_hold_q <= minus_hold_d;
      end
   end
`else
   assign plus_rep  = 1'b0;
   assign minus_rep = 1'b0;
`endif

   always_comb begin
      plus_d       = plus;
      minus_d      = minus;
      plus_prev_d  = plus_q;
      minus_prev_d = minus_q;
      plus_step    = (plus_q & ~plus_prev_q) | plus_rep;
      minus_step   = (minus_q & ~minus_prev_q) | minus_rep;
      value_d      = value_q;
      // Simultaneous plus and minus cancel; load_defaults overrides everything
      if (load_defaults) begin
         value_d = W'(DEF);
      end else if (plus_step && !minus_step) begin
         value_d = (value_q > W'(MAX - STEP)) ? W'(MAX) : value_q + W'(STEP);
      end else if (minus_step && !plus_step) begin
         value_d = (value_q < W'(MIN + STEP)) ? W'(MIN) : value_q - W'(STEP);
      end
   end

   always_ff @(negedge clk_2M5 or negedge rst_n) begin
      if (!rst_n) begin
         plus_q       <= 1'b0;
         plus_prev_q  <= 1'b0;
         minus_q      <= 1'b0;
         minus_prev_q <= 1'b0;
         value_q      <= W'(DEF);
      end else begin
         plus_q       <= plus_d;
         plus_prev_q  <= plus_prev_d;
         minus_q      <= minus_d;
         minus_prev_q <= minus_prev_d;
         value_q      <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/pop_timers.sv
// POP sequence generator: pump, Ramsey MW pair and probe/sample windows from falling clk_2M5 edges.
// Define POP_TIMERS_AUTOREPEAT_EN for hold-to-repeat on the adjust buttons.
module pop_timers
   import pop_timers_pkg::*;
(
   input logic         clk_2M5,
   input logic         rst_n,
   pop_timers_if.slave bus
);

   logic [PI2_W-1:0]  pi2_reg, pi2_sh_q, pi2_sh_d;
   logic [FREE_W-1:0] free_reg, free_sh_q, free_sh_d;
   phase_e            phase_q, phase_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cyc_len, cyc_rem;
   logic              pump_q, pump_d, probe_q, probe_d, mw_q, mw_d, sample_q, sample_d;

   pop_step_adjust #(
      .W(PI2_W), .DEF(PI2_DEF), .STEP(PI2_STEP), .MIN(PI2_MIN), .MAX(PI2_MAX)
   ) u_pi2 (
      .clk_2M5       (clk_2M5),
      .rst_n         (rst_n),
      .load_defaults (bus.load_defaults),
      .plus          (bus.pieovertwo_plus),
      .minus         (bus.pieovertwo_minus),
      .value         (pi2_reg)
   );

   pop_step_adjust #(
      .W(FREE_W), .DEF(FREE_DEF), .STEP(FREE_STEP), .MIN(FREE_MIN), .MAX(FREE_MAX)
   ) u_free (
      .clk_2M5       (clk_2M5),
      .rst_n         (rst_n),
      .load_defaults (bus.load_defaults),
      .plus          (bus.freeprecess_plus),
      .minus         (bus.freeprecess_minus),
      .value         (free_reg)
   );

   // cnt_q holds the cycles of phase_q still to issue; zero means phase_q has not started yet
   always_comb begin
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      pi2_sh_d  = pi2_sh_q;
      free_sh_d = free_sh_q;
      cyc_len   = phase_len(phase_q, pi2_sh_q, free_sh_q);
      cyc_rem   = '0;
      if (cnt_q == '0) begin
         cyc_rem = cyc_len - 1'b1;
         if (phase_q == PH_PUMP) begin
            pi2_sh_d  = pi2_reg;
            free_sh_d = free_reg;
         end
      end else begin
         cyc_rem = cnt_q - 1'b1;
      end
      if (cyc_rem == '0) begin
         phase_d = next_phase(phase_q);
         cnt_d   = '0;
      end else begin
         cnt_d   = cyc_rem;
      end
      pump_d   = (phase_q == PH_PUMP);
      mw_d     = (phase_q == PH_MW1) || (phase_q == PH_MW2);
      probe_d  = (phase_q == PH_PROBE);
      sample_d = (phase_q == PH_PROBE) && (cyc_rem < CNT_W'(PROBE_CYC - SAMPLE_DLY));
   end

   always_ff @(negedge clk_2M5 or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= PH_PUMP;
         cnt_q     <= '0;
         pi2_sh_q  <= PI2_W'(PI2_DEF);
         free_sh_q <= FREE_W'(FREE_DEF);
         pump_q    <= 1'b0;
         probe_q   <= 1'b0;
         mw_q      <= 1'b0;
         sample_q  <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         cnt_q     <= cnt_d;
         pi2_sh_q  <= pi2_sh_d;
         free_sh_q <= free_sh_d;
         pump_q    <= pump_d;
         probe_q   <= probe_d;
         mw_q      <= mw_d;
         sample_q  <= sample_d;
      end
   end

   assign bus.pump   = pump_q;
   assign bus.probe  = probe_q;
   assign bus.MW     = mw_q;
   assign bus.sample = sample_q;
   assign bus.phase  = phase_q;

endmodule

// File: tb/tb_pop_timers.sv
// Bench for pop_timers: per-period pulse widths measured by a monitor against a queue of
// expected pi/2 and free-precession values produced by a button-level reference model.
`timescale 1ns/1ps
module tb_pop_timers;
   import pop_timers_pkg::*;

   localparam int T_PUMP  = 1000;
   localparam int T_WAIT1 = 50;
   localparam int T_WAIT2 = 50;
   localparam int T_PROBE = 500;
   localparam int T_SDLY  = 50;
   localparam int NPER    = 12;
   localparam int TMO     = 10000;

   logic clk_2M5 = 1'b0;
   logic rst_n;

   pop_timers_if bus ();

   pop_timers dut (
      .clk_2M5 (clk_2M5),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   always #200 clk_2M5 = ~clk_2M5;

   initial begin : watchdog
      #(400.0 * 90000);
      $display("FAIL watchdog: simulation did not finish within 90000 cycles");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   int          pi2_m;
   int          free_m;
   logic        mon_done = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic sig_val(input int s);
      case (s)
         0:       return bus.pump;
         1:       return bus.MW;
         2:       return bus.probe;
         default: return bus.sample;
      endcase
   endfunction

   // Counts posedges while the selected output stays at lvl (bounded)
   task automatic run_len(input string name, input int s, input logic lvl, output int n);
      n = 0;
      while (sig_val(s) == lvl && n < TMO) begin
         @(posedge clk_2M5);
         n++;
      end
      if (n >= TMO) begin
         total++;
         bad++;
         $display("FAIL timeout %s: level still %0d after %0d cycles", name, lvl, n);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int sat(input int v, input int lo, input int hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   task automatic model_step(input int sel);
      case (sel)
         0:       pi2_m  = sat(pi2_m + 1, 1, 255);
         1:       pi2_m  = sat(pi2_m - 1, 1, 255);
         2:       free_m = sat(free_m + 25, 25, 4000);
         default: free_m = sat(free_m - 25, 25, 4000);
      endcase
   endtask

   // ---------------- drivers ----------------
   task automatic set_sig(input int sel, input logic v);
      case (sel)
         0:       bus.pieovertwo_plus   = v;
         1:       bus.pieovertwo_minus  = v;
         2:       bus.freeprecess_plus  = v;
         default: bus.freeprecess_minus = v;
      endcase
   endtask

   task automatic pulse(input int sel, input int hi, input int lo, input bit upd);
      set_sig(sel, 1'b1);
      repeat (hi) @(posedge clk_2M5);
      set_sig(sel, 1'b0);
      repeat (lo) @(posedge clk_2M5);
      if (upd) model_step(sel);
   endtask

   task automatic sim_pulse(input int reg_sel, input int hi, input int lo);
      set_sig(2 * reg_sel, 1'b1);
      set_sig(2 * reg_sel + 1, 1'b1);
      repeat (hi) @(posedge clk_2M5);
      set_sig(2 * reg_sel, 1'b0);
      set_sig(2 * reg_sel + 1, 1'b0);
      repeat (lo) @(posedge clk_2M5);
   endtask

   task automatic hold_defaults(input bit with_steps);
      bus.load_defaults = 1'b1;
      repeat (3) @(posedge clk_2M5);
      if (with_steps) begin
         pulse(0, 2, 2, 1'b0);
         pulse(2, 2, 2, 1'b0);
         pulse(1, 2, 2, 1'b0);
         pulse(3, 2, 2, 1'b0);
      end
      repeat (3) @(posedge clk_2M5);
      bus.load_defaults = 1'b0;
      pi2_m  = 25;
      free_m = 1250;
   endtask

   task automatic do_ops(input int p);
      int n;
      case (p)
         0: ;
         1: repeat (2) pulse(0, 300, 10, 1'b1);
         2: pulse(3, 5, 5, 1'b1);
         3: hold_defaults(1'b1);
         4: repeat (300) pulse(1, 2, 2, 1'b1);
         5: begin
            sim_pulse(0, 3, 3);
            sim_pulse(1, 3, 3);
            pulse(0, 2, 2, 1'b1);
         end
         6: begin
            repeat (120) pulse(2, 2, 2, 1'b1);
            repeat (10) pulse(0, 2, 2, 1'b1);
         end
         7: hold_defaults(1'b0);
         default: begin
            n = $urandom_range(1, 16);
            for (int i = 0; i < n; i++) begin
               if ($urandom_range(0, 7) == 0)
                  sim_pulse($urandom_range(0, 1), $urandom_range(1, 4), $urandom_range(1, 4));
               else
                  pulse($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(1, 4), 1'b1);
            end
         end
      endcase
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      int          pl, w1, m1, fr, m2, w2, sd, sw, idle;
      logic [31:0] e;
      wait (rst_n === 1'b1);
      run_len("first pump rise", 0, 1'b0, idle);
      for (int p = 0; p < NPER; p++) begin
         run_len("pump", 0, 1'b1, pl);
         run_len("wait1", 1, 1'b0, w1);
         run_len("mw1", 1, 1'b1, m1);
         run_len("free", 1, 1'b0, fr);
         run_len("mw2", 1, 1'b1, m2);
         run_len("wait2", 2, 1'b0, w2);
         run_len("sample_dly", 3, 1'b0, sd);
         run_len("sample_w", 3, 1'b1, sw);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: no expectation queued for period %0d", p);
            e = '0;
         end else begin
            e = exp_q.pop_front();
         end
         check("pump_len", pl, T_PUMP);
         check("wait1_len", w1, T_WAIT1);
         check("mw1_len", m1, int'(e[31:16]));
         check("free_len", fr, int'(e[15:0]));
         check("mw2_len", m2, int'(e[31:16]));
         check("wait2_len", w2, T_WAIT2);
         check("sample_dly", sd, T_SDLY);
         check("sample_len", sw, T_PROBE - T_SDLY);
         check("probe_end", int'(bus.probe), 0);
         check("pump_restart", int'(bus.pump), 1);
      end
      mon_done = 1'b1;
   end

   // ---------------- stimulus and directed reset tests ----------------
   initial begin : main
      int n, w;
      bus.load_defaults     = 1'b0;
      bus.pieovertwo_plus   = 1'b0;
      bus.pieovertwo_minus  = 1'b0;
      bus.freeprecess_plus  = 1'b0;
      bus.freeprecess_minus = 1'b0;
      rst_n  = 1'b0;
      pi2_m  = 25;
      free_m = 1250;
      repeat (3) @(posedge clk_2M5);
      check("rst_pump", int'(bus.pump), 0);
      check("rst_mw", int'(bus.MW), 0);
      check("rst_probe", int'(bus.probe), 0);
      check("rst_sample", int'(bus.sample), 0);
      exp_q.push_back({16'(pi2_m), 16'(free_m)});
      rst_n = 1'b1;
      run_len("stim first pump", 0, 1'b0, n);

      for (int p = 0; p < NPER; p++) begin
         repeat (3) @(posedge clk_2M5);
         do_ops(p);
         if (p < NPER - 1) begin
            exp_q.push_back({16'(pi2_m), 16'(free_m)});
            run_len("stim pump fall", 0, 1'b1, n);
            run_len("stim pump rise", 0, 1'b0, n);
         end
      end

      w = 0;
      while (!mon_done && w < 3 * TMO) begin
         @(posedge clk_2M5);
         w++;
      end
      if (!mon_done) begin
         total++;
         bad++;
         $display("FAIL monitor_done: monitor still busy after %0d cycles", w);
      end

      // Reset in the middle of FREE after a pending adjustment
      pulse(0, 2, 2, 1'b1);
      run_len("rt pump", 0, 1'b1, n);
      run_len("rt wait1", 1, 1'b0, n);
      run_len("rt mw1", 1, 1'b1, n);
      repeat (10) @(posedge clk_2M5);
      #37;
      rst_n = 1'b0;
      #1;
      check("free_rst_pump", int'(bus.pump), 0);
      check("free_rst_mw", int'(bus.MW), 0);
      check("free_rst_phase_is_pump", int'(bus.phase == PH_PUMP), 1);
      repeat (3) @(posedge clk_2M5);
      check("held_rst_pump", int'(bus.pump), 0);
      rst_n = 1'b1;
      pi2_m  = 25;
      free_m = 1250;
      @(posedge clk_2M5);
      check("restart_pump", int'(bus.pump), 1);
      run_len("rs pump", 0, 1'b1, n);
      check("restart_pump_len", n, T_PUMP);
      run_len("rs wait1", 1, 1'b0, n);
      check("restart_wait1", n, T_WAIT1);
      run_len("rs mw1", 1, 1'b1, n);
      check("restart_mw1", n, pi2_m);
      run_len("rs free", 1, 1'b0, n);
      check("restart_free", n, free_m);
      run_len("rs mw2", 1, 1'b1, n);
      check("restart_mw2", n, pi2_m);
      run_len("rs wait2", 2, 1'b0, n);
      run_len("rs sdly", 3, 1'b0, n);
      check("restart_sdly", n, T_SDLY);

      // Reset while sample is high clears it without waiting for a clock edge
      repeat (10) @(posedge clk_2M5);
      check("pre_rst_probe", int'(bus.probe), 1);
      check("pre_rst_sample", int'(bus.sample), 1);
      #37;
      rst_n = 1'b0;
      #1;
      check("probe_rst_probe", int'(bus.probe), 0);
      check("probe_rst_sample", int'(bus.sample), 0);
      repeat (2) @(posedge clk_2M5);
      rst_n = 1'b1;
      repeat (2) @(posedge clk_2M5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
